// File: rtl/riscv_imm_gen_pipe.sv
// Purpose : RISC-V immediate generator with PC-relative target, registered, valid/ready at both sides.
// Latency : 1 cycle (accepted at edge N, presented with o_valid=1 in cycle N+1).
// Backpress: 2-entry OUT+SKD buffer, full rate under stall; o_ready is registered and drops once SKD fills.
//
// Ports:
//   i_clk, i_rstn               clock, synchronous active-low reset
//   i_valid/o_ready, i_instr,   upstream handshake, instruction word,
//   i_imm_sel, i_pc             explicit format (AUTO_SEL=0) and PC
//   o_valid/i_ready             downstream handshake
//   o_imm, o_imm_type,          sign-extended immediate, resolved format,
//   o_illegal, o_target         unsupported-format flag, i_pc + o_imm
module riscv_imm_gen_pipe #(
   parameter int XLEN     = 32,
   parameter bit AUTO_SEL = 1'b1
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [31:0]     i_instr,
   input  logic [2:0]      i_imm_sel,
   input  logic [XLEN-1:0] i_pc,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_imm,
   output logic [2:0]      o_imm_type,
   output logic            o_illegal,
   output logic [XLEN-1:0] o_target
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("riscv_imm_gen_pipe: XLEN must be 32 or 64");
   end

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      typ;
      logic            ill;
      logic [XLEN-1:0] tgt;
   } ent_t;

   logic [2:0]  auto_fmt;
   logic [2:0]  sel_fmt;
   logic        sel_ill;
   logic [31:0] imm32;
   ent_t        new_ent;

   // Decode: every 32-bit form already carries instr[31] in bit 31, so
   // widening to XLEN is a plain signed extension of imm32.
   always_comb begin
      auto_fmt = FMT_NONE;
      case (i_instr[6:0])
         7'b0000011, 7'b0010011,
         7'b1100111, 7'b1110011: auto_fmt = FMT_I;
         7'b0100011:             auto_fmt = FMT_S;
         7'b1100011:             auto_fmt = FMT_B;
         7'b0110111, 7'b0010111: auto_fmt = FMT_U;
         7'b1101111:             auto_fmt = FMT_J;
         default:                auto_fmt = FMT_NONE;
      endcase

      if (AUTO_SEL) begin
         sel_fmt = auto_fmt;
         sel_ill = (auto_fmt == FMT_NONE);
      end else begin
         // Explicit NONE is a legitimate "no immediate" request; only 6/7 are bad.
         sel_fmt = i_imm_sel;
         sel_ill = (i_imm_sel >= 3'd6);
      end

      imm32 = '0;
      case (sel_fmt)
         FMT_I:   imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
         FMT_S:   imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         FMT_B:   imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8], 1'b0};
         FMT_U:   imm32 = {i_instr[31:12], 12'b0};
         FMT_J:   imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                           i_instr[20], i_instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase

      new_ent.imm = XLEN'($signed(imm32));
      new_ent.typ = sel_fmt;
      new_ent.ill = sel_ill;
      new_ent.tgt = i_pc + new_ent.imm;
   end

   ent_t out_q, out_d;
   ent_t skd_q, skd_d;
   logic out_vld_q, out_vld_d;
   logic skd_vld_q, skd_vld_d;
   logic rdy_q, rdy_d;
   logic acc;
   logic pop;

   always_comb begin
      out_d     = out_q;
      out_vld_d = out_vld_q;
      skd_d     = skd_q;
      skd_vld_d = skd_vld_q;
      acc       = i_valid & rdy_q;
      pop       = out_vld_q & i_ready;

      if (pop) begin
         if (skd_vld_q) begin
            out_d     = skd_q;
            skd_vld_d = 1'b0;
         end else begin
            out_vld_d = 1'b0;
         end
      end

      // acc implies SKD is empty (rdy_q is !skd_vld_q), so a pop above
      // never competes with a SKD refill here.
      if (acc) begin
         if (!out_vld_q || pop) begin
            out_d     = new_ent;
            out_vld_d = 1'b1;
         end else begin
            skd_d     = new_ent;
            skd_vld_d = 1'b1;
         end
      end

      rdy_d = !skd_vld_d;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         out_q     <= '0;
         out_vld_q <= 1'b0;
         skd_q     <= '0;
         skd_vld_q <= 1'b0;
         rdy_q     <= 1'b0;
      end else begin
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
         skd_q     <= skd_d;
         skd_vld_q <= skd_vld_d;
         rdy_q     <= rdy_d;
      end
   end

   assign o_ready    = rdy_q;
   assign o_valid    = out_vld_q;
   assign o_imm      = out_q.imm;
   assign o_imm_type = out_q.typ;
   assign o_illegal  = out_q.ill;
   assign o_target   = out_q.tgt;

endmodule
